// File: rtl/noise_sound_ctrl_if.sv
// Sound control port: CPU write side plus the generated enables and channel gates.
interface noise_sound_ctrl_if;
  logic       cpu_wr;
  logic [7:0] cpu_data;
  logic       clk_3MHz_en;
  logic       clk_6KHz_en;
  logic       sound_enable;
  logic       shell_en;
  logic       shell_ls;
  logic       explo_en;
  logic       explo_ls;
  logic [1:0] status;

  modport master (
    output cpu_wr, cpu_data,
    input  clk_3MHz_en, clk_6KHz_en, sound_enable, shell_en, shell_ls, explo_en, explo_ls,
           status
  );

  modport slave (
    input  cpu_wr, cpu_data,
    output clk_3MHz_en, clk_6KHz_en, sound_enable, shell_en, shell_ls, explo_en, explo_ls,
           status
  );
endinterface

// File: rtl/noise_sound_ctrl.sv
// Shell/explosion noise sequencer: CPU control latch, 3 MHz / 6 kHz enables and
// two independent channel FSMs with a minimum on-time so short pulses stay audible.
module noise_sound_ctrl #(
  parameter int unsigned CLK_DIV_3M = 4,
  parameter int unsigned DIV_6K     = 512,
  parameter int unsigned MIN_HOLD   = 12
) (
  input logic               clk,
  input logic               reset,
  noise_sound_ctrl_if.slave bus
);

  localparam int unsigned W3 = (CLK_DIV_3M > 1) ? $clog2(CLK_DIV_3M) : 1;
  localparam int unsigned W6 = (DIV_6K > 1) ? $clog2(DIV_6K) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  // Channel index 0 = shell, 1 = explo.
  logic [W3-1:0] cnt3_q;
  logic [W6-1:0] cnt6_q;
  logic          en3;
  logic          tick;
  logic          snd_q;
  logic          req_q  [2];
  logic          lsl_q  [2];
  logic [1:0]    state_q[2];
  logic [1:0]    state_d[2];
  logic [7:0]    cnt_q  [2];
  logic [7:0]    cnt_d  [2];
  logic [7:0]    cnt_dec[2];
  logic          ls_q   [2];
  logic          ls_d   [2];
  logic          unused_data;

  assign en3  = (cnt3_q == W3'(CLK_DIV_3M - 1));
  assign tick = en3 && (cnt6_q == W6'(DIV_6K - 1));

  // Clock-enable dividers; the 6 kHz counter only moves on 3 MHz enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt3_q <= '0;
      cnt6_q <= '0;
    end else begin
      cnt3_q <= en3 ? '0 : cnt3_q + W3'(1);
      if (en3) cnt6_q <= (cnt6_q == W6'(DIV_6K - 1)) ? '0 : cnt6_q + W6'(1);
    end
  end

  // CPU control latch; bits 4, 6 and 7 are don't-care.
  always_ff @(posedge clk) begin
    if (reset) begin
      snd_q    <= 1'b0;
      req_q[0] <= 1'b0;
      lsl_q[0] <= 1'b0;
      req_q[1] <= 1'b0;
      lsl_q[1] <= 1'b0;
    end else if (bus.cpu_wr) begin
      snd_q    <= bus.cpu_data[5];
      req_q[0] <= bus.cpu_data[3];
      lsl_q[0] <= bus.cpu_data[2];
      req_q[1] <= bus.cpu_data[1];
      lsl_q[1] <= bus.cpu_data[0];
    end
  end

  assign unused_data = ^{bus.cpu_data[7:6], bus.cpu_data[4]};

  // Channel next-state: global kill first, then IDLE/RUN/HOLD with hold countdown.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      ls_d[c]    = ls_q[c];
      cnt_dec[c] = (tick && cnt_q[c] != 8'd0) ? cnt_q[c] - 8'd1 : cnt_q[c];
      if (!snd_q) begin
        state_d[c] = StIdle;
        cnt_d[c]   = 8'd0;
        ls_d[c]    = 1'b0;
      end else begin
        unique case (state_q[c])
          StIdle: begin
            if (req_q[c]) begin
              state_d[c] = StRun;
              cnt_d[c]   = 8'(MIN_HOLD);
              ls_d[c]    = lsl_q[c];
            end
          end
          StRun: begin
            if (req_q[c]) begin
              cnt_d[c] = cnt_dec[c];
              ls_d[c]  = lsl_q[c];
            end else if (cnt_dec[c] == 8'd0) begin
              state_d[c] = StIdle;
              cnt_d[c]   = 8'd0;
              ls_d[c]    = 1'b0;
            end else begin
              // ls stays at its last RUN value while holding.
              state_d[c] = StHold;
              cnt_d[c]   = cnt_dec[c];
            end
          end
          StHold: begin
            if (req_q[c]) begin
              state_d[c] = StRun;
              cnt_d[c]   = 8'(MIN_HOLD);
              ls_d[c]    = lsl_q[c];
            end else if (cnt_dec[c] == 8'd0) begin
              state_d[c] = StIdle;
              cnt_d[c]   = 8'd0;
              ls_d[c]    = 1'b0;
            end else begin
              cnt_d[c] = cnt_dec[c];
            end
          end
          default: begin
            state_d[c] = StIdle;
            cnt_d[c]   = 8'd0;
            ls_d[c]    = 1'b0;
          end
        endcase
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        state_q[c] <= StIdle;
        cnt_q[c]   <= 8'd0;
        ls_q[c]    <= 1'b0;
      end else begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        ls_q[c]    <= ls_d[c];
      end
    end
  end

  assign bus.clk_3MHz_en  = en3;
  assign bus.clk_6KHz_en  = tick;
  assign bus.sound_enable = snd_q;
  assign bus.shell_en     = (state_q[0] != StIdle);
  assign bus.shell_ls     = ls_q[0];
  assign bus.explo_en     = (state_q[1] != StIdle);
  assign bus.explo_ls     = ls_q[1];
  assign bus.status       = {state_q[1] != StIdle, state_q[0] != StIdle};

endmodule

// File: tb/tb_noise_sound_ctrl.sv
// Randomised bench for noise_sound_ctrl: a behavioural model predicts every output
// after each clock edge into a queue; a monitor pops and compares on the falling edge.
module tb_noise_sound_ctrl;
  localparam int unsigned Div3   = 4;
  localparam int unsigned Div6   = 8;
  localparam int unsigned Hold   = 3;
  localparam int unsigned Period = Div3 * Div6;

  logic clk = 1'b0;
  logic reset;

  noise_sound_ctrl_if bus ();

  noise_sound_ctrl #(
    .CLK_DIV_3M(Div3),
    .DIV_6K    (Div6),
    .MIN_HOLD  (Hold)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];

  // Model state: cycles since reset, latched controls, and per-channel burst status.
  int cyc;
  bit m_snd;
  bit m_req [2];
  bit m_lsl [2];
  bit m_on  [2];
  bit m_hold[2];
  bit m_ls  [2];
  int m_rem [2];

  task automatic chan_off(input int c);
    m_on[c]   = 0;
    m_hold[c] = 0;
    m_rem[c]  = 0;
    m_ls[c]   = 0;
  endtask

  task automatic model_step();
    bit tick;
    if (reset) begin
      cyc   = 0;
      m_snd = 0;
      for (int c = 0; c < 2; c++) begin
        m_req[c] = 0;
        m_lsl[c] = 0;
        chan_off(c);
      end
    end else begin
      tick = (cyc % Period) == Period - 1;
      for (int c = 0; c < 2; c++) begin
        if (!m_snd) chan_off(c);
        else if (!m_on[c]) begin
          if (m_req[c]) begin
            m_on[c]   = 1;
            m_hold[c] = 0;
            m_rem[c]  = Hold;
            m_ls[c]   = m_lsl[c];
          end
        end else if (m_req[c] && m_hold[c]) begin
          m_hold[c] = 0;
          m_rem[c]  = Hold;
          m_ls[c]   = m_lsl[c];
        end else begin
          if (tick && m_rem[c] > 0) m_rem[c]--;
          if (m_req[c]) m_ls[c] = m_lsl[c];
          else if (m_rem[c] == 0) chan_off(c);
          else m_hold[c] = 1;
        end
      end
      if (bus.cpu_wr) begin
        m_snd    = bus.cpu_data[5];
        m_req[0] = bus.cpu_data[3];
        m_lsl[0] = bus.cpu_data[2];
        m_req[1] = bus.cpu_data[1];
        m_lsl[1] = bus.cpu_data[0];
      end
      cyc++;
    end
    exp_q.push_back({(cyc % Div3) == Div3 - 1, (cyc % Period) == Period - 1, m_snd,
                     m_on[0], m_ls[0], m_on[1], m_ls[1], m_on[1], m_on[0]});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    logic [8:0] got;
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      got = {bus.clk_3MHz_en, bus.clk_6KHz_en, bus.sound_enable, bus.shell_en, bus.shell_ls,
             bus.explo_en, bus.explo_ls, bus.status};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty t=%0t got=%b required=<prediction>", $time, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          fails++;
          if (fails <= 20)
            $display("FAIL outputs t=%0t got=%b required=%b (3M,6K,snd,sh_en,sh_ls,ex_en,ex_ls,st)",
                     $time, got, exp);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [7:0] d);
    @(negedge clk);
    bus.cpu_wr   = 1'b1;
    bus.cpu_data = d;
    @(negedge clk);
    bus.cpu_wr   = 1'b0;
    bus.cpu_data = $urandom_range(0, 255);
  endtask

  task automatic write2(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.cpu_wr   = 1'b1;
    bus.cpu_data = a;
    @(negedge clk);
    bus.cpu_data = b;
    @(negedge clk);
    bus.cpu_wr   = 1'b0;
  endtask

  initial begin
    logic [7:0] pool[10];
    logic [7:0] d;
    pool = '{8'h28, 8'h2C, 8'h22, 8'h23, 8'h2A, 8'h2F, 8'h20, 8'h0A, 8'h00, 8'hD8};
    reset        = 1'b1;
    bus.cpu_wr   = 1'b0;
    bus.cpu_data = 8'h00;
    idle(3);
    reset = 1'b0;
    idle(80);
    // Short shell pulse, then explo ls tracking and freeze.
    write2(8'h28, 8'h20);
    idle(120);
    write(8'h22);
    idle(5);
    write(8'h23);
    idle(5);
    write(8'h20);
    idle(110);
    // Both running, then global kill.
    write(8'h2A);
    idle(10);
    write(8'h0A);
    idle(10);
    // Reset in the middle of a hold.
    write2(8'h2F, 8'h20);
    idle(20);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(10);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) d = pool[$urandom_range(0, 9)];
      else d = 8'($urandom) | (($urandom_range(0, 3) != 0) ? 8'h20 : 8'h00);
      if ($urandom_range(0, 4) == 0) write2(d, pool[$urandom_range(0, 9)]);
      else write(d);
      idle($urandom_range(0, 70));
      if ($urandom_range(0, 40) == 0) begin
        reset = 1'b1;
        idle($urandom_range(1, 3));
        reset = 1'b0;
      end
    end
    idle(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
